// File: rtl/onehot_counter_param_if.sv
// Control and status bundle for onehot_counter_param.
// The master side drives the count controls; the slave side is the counter.
interface onehot_counter_param_if #(
    parameter int WIDTH = 3
);
    logic                    enable;
    logic                    up_down;
    logic                    load;
    logic [WIDTH-1:0]        load_value;
    logic [WIDTH-1:0]        count;
    logic [(1<<WIDTH)-1:0]   onehot;
    logic [(1<<WIDTH)-1:0]   onehot_n;
    logic                    terminal;
    logic                    wrapped;

    modport master (
        output enable, up_down, load, load_value,
        input  count, onehot, onehot_n, terminal, wrapped
    );

    modport slave (
        input  enable, up_down, load, load_value,
        output count, onehot, onehot_n, terminal, wrapped
    );
endinterface

// File: rtl/onehot_counter_param.sv
// Modulo up/down counter with a registered one-hot decode, used as a slot/strobe sequencer.
// Supports parallel load with clamping, wrap or saturate at the ends, and a one-cycle wrap pulse.
module onehot_counter_param #(
    parameter int WIDTH    = 3,
    parameter int MODULO   = 8,
    parameter int SATURATE = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    onehot_counter_param_if.slave    bus
);
    localparam int               OH_BITS   = 1 << WIDTH;
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0]   count_q, count_d;
    logic [OH_BITS-1:0] onehot_q, onehot_d;
    logic               wrapped_q, wrapped_d;

    always_comb begin
        count_d   = count_q;
        wrapped_d = 1'b0;
        if (bus.load) begin
            count_d = (bus.load_value > MAX_COUNT) ? MAX_COUNT : bus.load_value;
        end else if (bus.enable) begin
            if (bus.up_down) begin
                if (count_q != MAX_COUNT) begin
                    count_d = count_q + WIDTH'(1);
                end else if (SATURATE == 0) begin
                    count_d   = '0;
                    wrapped_d = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else if (SATURATE == 0) begin
                    count_d   = MAX_COUNT;
                    wrapped_d = 1'b1;
                end
            end
        end
    end

    // Decode from the next-state value so onehot lands on the same edge as count.
    always_comb begin
        onehot_d           = '0;
        onehot_d[count_d]  = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= '0;
            onehot_q  <= OH_BITS'(1);
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            onehot_q  <= onehot_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.onehot   = onehot_q;
    assign bus.onehot_n = ~onehot_q;
    assign bus.wrapped  = wrapped_q;
    assign bus.terminal = (bus.up_down & (count_q == MAX_COUNT)) |
                          (~bus.up_down & (count_q == '0));
endmodule

// File: tb/tb_onehot_counter_param.sv
// Directed bench for onehot_counter_param: three instances cover mod-8 wrap, mod-6 wrap and mod-6 saturate.
// Vectors carry hand-computed count/wrapped/terminal; onehot is checked against 1 << count.
module tb_onehot_counter_param;
    logic clock = 1'b0;
    logic rstA = 1'b0, rstB = 1'b0, rstC = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    onehot_counter_param_if #(.WIDTH(3)) ifA ();
    onehot_counter_param_if #(.WIDTH(3)) ifB ();
    onehot_counter_param_if #(.WIDTH(3)) ifC ();

    onehot_counter_param #(.WIDTH(3), .MODULO(8), .SATURATE(0)) dutA (.clock(clock), .reset(rstA), .bus(ifA.slave));
    onehot_counter_param #(.WIDTH(3), .MODULO(6), .SATURATE(0)) dutB (.clock(clock), .reset(rstB), .bus(ifB.slave));
    onehot_counter_param #(.WIDTH(3), .MODULO(6), .SATURATE(1)) dutC (.clock(clock), .reset(rstC), .bus(ifC.slave));

    typedef struct {
        int         sel;
        logic       rst, en, ud, ld;
        logic [2:0] lv;
        logic [2:0] expCount;
        logic       expWrap;
        logic       expTerm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int s, logic r, logic e, logic u, logic l, logic [2:0] lv,
                                logic [2:0] c, logic w, logic t);
        vec_t v;
        v.sel = s; v.rst = r; v.en = e; v.ud = u; v.ld = l; v.lv = lv;
        v.expCount = c; v.expWrap = w; v.expTerm = t;
        return v;
    endfunction

    task automatic compare(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s vec=%0d actual=0x%02h expected=0x%02h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ifA.enable = 1'b0; ifA.load = 1'b0; ifA.load_value = '0;
        ifB.enable = 1'b0; ifB.load = 1'b0; ifB.load_value = '0;
        ifC.enable = 1'b0; ifC.load = 1'b0; ifC.load_value = '0;
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        case (v.sel)
            0: begin rstA = v.rst; ifA.enable = v.en; ifA.up_down = v.ud; ifA.load = v.ld; ifA.load_value = v.lv; end
            1: begin rstB = v.rst; ifB.enable = v.en; ifB.up_down = v.ud; ifB.load = v.ld; ifB.load_value = v.lv; end
            default: begin rstC = v.rst; ifC.enable = v.en; ifC.up_down = v.ud; ifC.load = v.ld; ifC.load_value = v.lv; end
        endcase
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        logic [2:0] cnt;
        logic [7:0] oh, ohn, expOh;
        logic       wr, tm;
        case (v.sel)
            0:       begin cnt = ifA.count; oh = ifA.onehot; ohn = ifA.onehot_n; wr = ifA.wrapped; tm = ifA.terminal; end
            1:       begin cnt = ifB.count; oh = ifB.onehot; ohn = ifB.onehot_n; wr = ifB.wrapped; tm = ifB.terminal; end
            default: begin cnt = ifC.count; oh = ifC.onehot; ohn = ifC.onehot_n; wr = ifC.wrapped; tm = ifC.terminal; end
        endcase
        expOh = 8'd1 << v.expCount;
        compare("count",    idx, {5'd0, cnt}, {5'd0, v.expCount});
        compare("onehot",   idx, oh,  expOh);
        compare("onehot_n", idx, ohn, ~expOh);
        compare("wrapped",  idx, {7'd0, wr}, {7'd0, v.expWrap});
        compare("terminal", idx, {7'd0, tm}, {7'd0, v.expTerm});
    endtask

    initial begin
        ifA.up_down = 1'b1; ifB.up_down = 1'b1; ifC.up_down = 1'b1;

        // DUT A: mod 8, wrap
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 4, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 5, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 6, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 7, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 5, 5, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 7, 1, 0));
        // DUT B: mod 6, wrap
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 5, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 4, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 5, 1, 0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 3, 3, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 7, 5, 0, 1));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 4, 4, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 2, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 0, 1, 0, 0, 2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 5, 5, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 5, 0, 1));
        // DUT C: mod 6, saturate
        vecs.push_back(mk(2, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 1, 4, 4, 0, 0));
        vecs.push_back(mk(2, 0, 1, 1, 0, 0, 5, 0, 1));
        vecs.push_back(mk(2, 0, 1, 1, 0, 0, 5, 0, 1));
        vecs.push_back(mk(2, 0, 1, 1, 0, 0, 5, 0, 1));
        vecs.push_back(mk(2, 0, 1, 0, 0, 0, 4, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(2, 0, 0, 0, 1, 7, 5, 0, 0));
        vecs.push_back(mk(2, 0, 1, 0, 0, 0, 4, 0, 0));
        vecs.push_back(mk(2, 1, 1, 0, 1, 3, 0, 0, 1));

        @(negedge clock);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // B sits at 5 after the last B vector is undone by C traffic? No: B holds at 5 while C runs.
        begin
            logic [2:0] model;
            model = 3'd5;
            ifB.up_down = 1'b1;
            for (int i = 0; i < 14; i++) begin
                ifB.enable = 1'b1;
                @(posedge clock);
                #1;
                model = (model == 3'd5) ? 3'd0 : model + 3'd1;
                compare("seqB_count",   100 + i, {5'd0, ifB.count}, {5'd0, model});
                compare("seqB_high_oh", 100 + i, {6'd0, ifB.onehot[7:6]}, 8'd0);
                compare("seqB_high_n",  100 + i, {6'd0, ifB.onehot_n[7:6]}, 8'd3);
                compare("seqB_wrapped", 100 + i, {7'd0, ifB.wrapped}, {7'd0, (model == 3'd0)});
            end
            ifB.enable = 1'b0;
        end

        // Reset held for several edges with enable and load active keeps A parked at zero.
        ifA.enable = 1'b1; ifA.up_down = 1'b1; ifA.load = 1'b1; ifA.load_value = 3'd6;
        rstA = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            compare("rstHold_count",  200 + i, {5'd0, ifA.count}, 8'd0);
            compare("rstHold_onehot", 200 + i, ifA.onehot, 8'h01);
        end
        rstA = 1'b0; ifA.load = 1'b0;
        @(posedge clock);
        #1;
        compare("rstRelease_count", 203, {5'd0, ifA.count}, 8'd1);
        ifA.enable = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/onehot_counter_param.md
Name: onehot_counter_param

Overview:
- Parametrised synchronous up/down counter with a registered one-hot decoded output and its complement.
- Successor to the fixed 3-bit counter-plus-3-to-8-decoder block.
- Adds: generic width, programmable modulo, direction control, parallel load, wrap/saturate mode, and terminal/wrap flags.
- Used as a sequencer/strobe generator. Each one-hot bit selects one time slot or channel.

Parameters:
- WIDTH, 3, counter width in bits; WIDTH >= 1.
- MODULO, 8, count range is 0..MODULO-1; 2 <= MODULO <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at the ends; 1 = hold at the ends.

Ports:
- clock  input  1  rising-edge clock; the only clock domain.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count-enable; when low the counter holds.
- up_down  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel-load strobe.
- load_value  input  WIDTH  value loaded when load is high.
- count  output  WIDTH  registered count.
- onehot  output  2**WIDTH  registered decode of count.
- onehot_n  output  2**WIDTH  bitwise complement of onehot.
- terminal  output  1  combinational end-of-range flag.
- wrapped  output  1  registered one-cycle pulse on wrap-around.

Behaviour:
- All state changes on the rising edge of clock. There are no asynchronous paths.
- Update priority per edge: reset > load > enable > hold.
- Reset:
  - count = 0.
  - onehot = 1 (bit 0 set, all others 0).
  - onehot_n = ~onehot.
  - wrapped = 0.
  - Reset asserted mid-count or during load wins unconditionally.
- onehot updates on the same edge as count: onehot == (1 << count) at all times. There is no lag cycle.
- onehot bits at index >= MODULO are always 0. The corresponding onehot_n bits are always 1.
- Load:
  - count <= load_value if load_value <= MODULO-1; otherwise count <= MODULO-1 (clamped).
  - wrapped <= 0.
  - enable and up_down are ignored that cycle.
- Count up (enable=1, up_down=1):
  - count < MODULO-1: count+1, wrapped <= 0.
  - count == MODULO-1 and SATURATE=0: count <= 0, wrapped <= 1.
  - count == MODULO-1 and SATURATE=1: hold, wrapped <= 0.
- Count down (enable=1, up_down=0):
  - count > 0: count-1, wrapped <= 0.
  - count == 0 and SATURATE=0: count <= MODULO-1, wrapped <= 1.
  - count == 0 and SATURATE=1: hold, wrapped <= 0.
- Hold (enable=0, no load): count and onehot hold; wrapped <= 0.
- wrapped is high for exactly one cycle per wrap event. It stays high on consecutive cycles only if consecutive edges each wrap, which can happen with MODULO=2.
- terminal = (up_down & count==MODULO-1) | (~up_down & count==0). It is independent of enable and SATURATE.
- Direction changes take effect on the next enabled edge. There is no internal pipeline, so latency from input to count/onehot is one edge.
- Arithmetic is modulo MODULO only; count never takes a value >= MODULO.

Test Plan:
- WIDTH=3, MODULO=8, SATURATE=0: reset, then enable=1, up_down=1 for 9 edges -> count 1..7,0,1; onehot 0x02..0x80,0x01,0x02; onehot_n = ~onehot; wrapped=1 only in the cycle count==0; terminal=1 while count==7.
- WIDTH=3, MODULO=6, SATURATE=0, counting down from reset -> count 5,4,3,2,1,0,5; onehot bits 6 and 7 always 0; wrapped pulses on each 0->5 transition; terminal=1 at count 0.
- WIDTH=3, MODULO=6, SATURATE=1: load 4, count up 3 edges -> 5,5,5 with wrapped=0 and terminal=1. Then count down 7 edges -> 4,3,2,1,0,0,0.
- Load priority: load=1, load_value=3, enable=1 on the same edge -> count=3, onehot=0x08. Then load_value=7 with MODULO=6 -> count=5 (clamped), wrapped=0.
- Reset mid-operation: at count=4, assert reset together with load=1 and enable=1 -> next edge count=0, onehot=0x01, wrapped=0. Count resumes from 0 after reset is released.
- Hold: enable=0 for 5 edges at count=2 -> count, onehot and terminal are stable, wrapped=0. Toggling up_down while held changes only terminal, and only when count is at an end.
